// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: selects the next fetch PC from corrections, interrupts,
// ID jumps, stalls and predictions, and carries PC/valid through IF->ID->EXE.
module fetch_pc_sequencer #(
    parameter int unsigned     PC_W         = 10,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter logic [PC_W-1:0] ISR_VECTOR   = PC_W'(10'h3C0)
) (
    input  logic            CLK,
    input  logic            nrst,
    input  logic            en,
    input  logic            stall,
    input  logic            if_prediction,
    input  logic [PC_W-1:0] if_PBT,
    input  logic [1:0]      exe_correction,
    input  logic [PC_W-1:0] exe_CNI,
    input  logic [PC_W-1:0] exe_PBT,
    input  logic            branch_flush,
    input  logic            id_is_jump,
    input  logic            id_jump_in_bht,
    input  logic [PC_W-1:0] id_branchtarget,
    input  logic            isr_req,
    input  logic            exe_is_mret,
    output logic [PC_W-1:0] if_PC,
    output logic [PC_W-1:0] id_PC,
    output logic [PC_W-1:0] exe_PC,
    output logic            id_valid,
    output logic            exe_valid,
    output logic            ISR_running,
    output logic            isr_ack
);

    typedef enum logic {
        NORMAL = 1'b0,
        ISR    = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PC_W-1:0] saved_pc;

    logic            correction;
    logic            jump_redirect;
    logic            jump_sel;
    logic            isr_take;
    logic            isr_ret;
    logic            flush;
    logic [PC_W-1:0] next_pc;

    assign correction    = exe_correction[1];
    assign jump_redirect = id_valid && id_is_jump && !id_jump_in_bht;

    // Mode register
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state_q <= NORMAL;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // Mode transitions: enter on an accepted request, leave on a return
    always_comb begin
        state_d = state_q;
        if (isr_take) begin
            state_d = ISR;
        end else if (isr_ret) begin
            state_d = NORMAL;
        end
    end

    // Interrupt entry/return decode; a correction defers a pending return
    always_comb begin
        isr_take = 1'b0;
        isr_ret  = 1'b0;
        case (state_q)
            NORMAL: isr_take = isr_req && en && !correction && !jump_redirect && !branch_flush;
            ISR:    isr_ret  = exe_valid && exe_is_mret && !correction;
            default: begin
                isr_take = 1'b0;
                isr_ret  = 1'b0;
            end
        endcase
    end

    // Next-PC priority select and pipeline squash decode
    always_comb begin
        jump_sel = 1'b0;
        if (exe_correction == 2'b11) begin
            next_pc = exe_PBT;
        end else if (exe_correction == 2'b10) begin
            next_pc = exe_CNI;
        end else if (isr_ret) begin
            next_pc = saved_pc;
        end else if (isr_take) begin
            next_pc = ISR_VECTOR;
        end else if (jump_redirect) begin
            next_pc  = id_branchtarget;
            jump_sel = 1'b1;
        end else if (stall) begin
            next_pc = if_PC;
        end else if (if_prediction) begin
            next_pc = if_PBT;
        end else begin
            next_pc = if_PC + PC_W'(1);
        end
        flush = branch_flush || correction || isr_take || isr_ret || jump_sel;
    end

    // PC and IF/ID/EXE pipeline registers; an ID jump advances past a stall
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            if_PC     <= RESET_VECTOR;
            id_PC     <= '0;
            exe_PC    <= '0;
            id_valid  <= 1'b0;
            exe_valid <= 1'b0;
        end else if (en) begin
            if_PC <= next_pc;
            if (!stall || jump_sel) begin
                id_PC  <= if_PC;
                exe_PC <= id_PC;
            end
            if (flush) begin
                id_valid <= 1'b0;
            end else if (!stall) begin
                id_valid <= 1'b1;
            end
            if (jump_sel) begin
                exe_valid <= id_valid;
            end else if (flush || stall) begin
                exe_valid <= 1'b0;
            end else begin
                exe_valid <= id_valid;
            end
        end
    end

    // Interrupt status, entry pulse and return address
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            ISR_running <= 1'b0;
            isr_ack     <= 1'b0;
            saved_pc    <= '0;
        end else if (en) begin
            ISR_running <= (state_d == ISR);
            isr_ack     <= isr_take;
            if (isr_take) begin
                saved_pc <= id_valid ? id_PC : if_PC;
            end
        end else begin
            isr_ack <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed and randomized checks of fetch_pc_sequencer against a cycle model.
module tb_fetch_pc_sequencer;

    logic       CLK = 1'b0;
    logic       nrst;
    logic       en;
    logic       stall;
    logic       if_prediction;
    logic [9:0] if_PBT;
    logic [1:0] exe_correction;
    logic [9:0] exe_CNI;
    logic [9:0] exe_PBT;
    logic       branch_flush;
    logic       id_is_jump;
    logic       id_jump_in_bht;
    logic [9:0] id_branchtarget;
    logic       isr_req;
    logic       exe_is_mret;
    logic [9:0] if_PC;
    logic [9:0] id_PC;
    logic [9:0] exe_PC;
    logic       id_valid;
    logic       exe_valid;
    logic       ISR_running;
    logic       isr_ack;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [9:0] m_pc, m_id_pc, m_exe_pc, m_saved;
    logic       m_id_v, m_exe_v, m_isr, m_ack;

    fetch_pc_sequencer dut (
        .CLK             (CLK),
        .nrst            (nrst),
        .en              (en),
        .stall           (stall),
        .if_prediction   (if_prediction),
        .if_PBT          (if_PBT),
        .exe_correction  (exe_correction),
        .exe_CNI         (exe_CNI),
        .exe_PBT         (exe_PBT),
        .branch_flush    (branch_flush),
        .id_is_jump      (id_is_jump),
        .id_jump_in_bht  (id_jump_in_bht),
        .id_branchtarget (id_branchtarget),
        .isr_req         (isr_req),
        .exe_is_mret     (exe_is_mret),
        .if_PC           (if_PC),
        .id_PC           (id_PC),
        .exe_PC          (exe_PC),
        .id_valid        (id_valid),
        .exe_valid       (exe_valid),
        .ISR_running     (ISR_running),
        .isr_ack         (isr_ack)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        en = 1'b1; stall = 1'b0; if_prediction = 1'b0; if_PBT = '0;
        exe_correction = 2'b00; exe_CNI = '0; exe_PBT = '0; branch_flush = 1'b0;
        id_is_jump = 1'b0; id_jump_in_bht = 1'b0; id_branchtarget = '0;
        isr_req = 1'b0; exe_is_mret = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = 10'h000; m_id_pc = '0; m_exe_pc = '0; m_saved = '0;
        m_id_v = 1'b0; m_exe_v = 1'b0; m_isr = 1'b0; m_ack = 1'b0;
    endtask

    // One clock of the behavioural rules, evaluated from the current inputs
    task automatic model_step();
        logic       corr, ret, jmp, take, jsel, fl;
        logic [9:0] npc, nid_pc, nexe_pc;
        logic       nid_v, nexe_v;
        if (!en) begin
            m_ack = 1'b0;
            return;
        end
        corr = exe_correction[1];
        ret  = m_isr && m_exe_v && exe_is_mret && !corr;
        jmp  = m_id_v && id_is_jump && !id_jump_in_bht;
        take = !m_isr && isr_req && !corr && !jmp && !branch_flush;
        jsel = jmp && !corr && !ret;
        if (exe_correction == 2'b11)      npc = exe_PBT;
        else if (exe_correction == 2'b10) npc = exe_CNI;
        else if (ret)                     npc = m_saved;
        else if (take)                    npc = 10'h3C0;
        else if (jmp)                     npc = id_branchtarget;
        else if (stall)                   npc = m_pc;
        else if (if_prediction)           npc = if_PBT;
        else                              npc = 10'((int'(m_pc) + 1) % 1024);
        fl = branch_flush || corr || take || ret || jsel;
        if (jsel) begin
            nid_pc = m_pc; nid_v = 1'b0; nexe_pc = m_id_pc; nexe_v = m_id_v;
        end else if (stall) begin
            nid_pc = m_id_pc; nid_v = fl ? 1'b0 : m_id_v; nexe_pc = m_exe_pc; nexe_v = 1'b0;
        end else begin
            nid_pc = m_pc; nid_v = !fl; nexe_pc = m_id_pc; nexe_v = fl ? 1'b0 : m_id_v;
        end
        if (take) m_saved = m_id_v ? m_id_pc : m_pc;
        if (take) m_isr = 1'b1;
        else if (ret) m_isr = 1'b0;
        m_ack = take;
        m_pc = npc; m_id_pc = nid_pc; m_id_v = nid_v; m_exe_pc = nexe_pc; m_exe_v = nexe_v;
    endtask

    task automatic compare_all();
        check("if_PC", 32'(if_PC), 32'(m_pc));
        check("id_valid", 32'(id_valid), 32'(m_id_v));
        check("exe_valid", 32'(exe_valid), 32'(m_exe_v));
        if (m_id_v) check("id_PC", 32'(id_PC), 32'(m_id_pc));
        if (m_exe_v) check("exe_PC", 32'(exe_PC), 32'(m_exe_pc));
        check("ISR_running", 32'(ISR_running), 32'(m_isr));
        check("isr_ack", 32'(isr_ack), 32'(m_ack));
    endtask

    // Apply current inputs for one edge, then compare on the falling edge
    task automatic tick();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        compare_all();
    endtask

    initial begin
        idle_inputs();
        nrst = 1'b0;
        model_reset();
        #12;
        check("reset_if_PC", 32'(if_PC), 32'h000);
        check("reset_valids", 32'({id_valid, exe_valid, ISR_running, isr_ack}), 32'h0);
        @(negedge CLK);
        nrst = 1'b1;

        // Sequential fetch
        tick(); check("seq_pc1", 32'(if_PC), 32'h001); check("seq_idv", 32'(id_valid), 32'h1);
        tick(); check("seq_pc2", 32'(if_PC), 32'h002);
        tick(); check("seq_pc3", 32'(if_PC), 32'h003); check("seq_exe", 32'(exe_PC), 32'h001);
        tick(); tick(); check("seq_pc5", 32'(if_PC), 32'h005);

        // Prediction, then CNI correction
        if_prediction = 1'b1; if_PBT = 10'h040;
        tick(); check("pred_pc", 32'(if_PC), 32'h040);
        idle_inputs(); exe_correction = 2'b10; exe_CNI = 10'h006;
        tick(); check("cni_pc", 32'(if_PC), 32'h006);
        check("cni_valids", 32'({id_valid, exe_valid}), 32'h0);
        idle_inputs();
        tick();

        // Unpredicted ID jump wins over a stall
        id_is_jump = 1'b1; id_branchtarget = 10'h120; stall = 1'b1;
        tick(); check("jmp_pc", 32'(if_PC), 32'h120); check("jmp_idv", 32'(id_valid), 32'h0);
        check("jmp_exe", 32'({exe_valid, exe_PC}), 32'({1'b1, 10'h006}));
        idle_inputs();

        // Interrupt entry with id_PC=0x33, then return
        exe_correction = 2'b11; exe_PBT = 10'h033;
        tick(); idle_inputs(); tick();
        isr_req = 1'b1;
        tick(); check("isr_pc", 32'(if_PC), 32'h3C0);
        check("isr_flags", 32'({ISR_running, isr_ack}), 32'h3);
        isr_req = 1'b0;
        tick(); check("isr_ack_pulse", 32'(isr_ack), 32'h0);
        tick();
        exe_is_mret = 1'b1;
        tick(); check("ret_pc", 32'(if_PC), 32'h033); check("ret_isr", 32'(ISR_running), 32'h0);
        idle_inputs();

        // Request concurrent with a correction is deferred one cycle
        isr_req = 1'b1; exe_correction = 2'b11; exe_PBT = 10'h080;
        tick(); check("defer_pc", 32'(if_PC), 32'h080); check("defer_ack", 32'(isr_ack), 32'h0);
        exe_correction = 2'b00;
        tick(); check("defer_take", 32'(isr_ack), 32'h1);
        isr_req = 1'b0;
        tick(); tick();
        exe_is_mret = 1'b1;
        tick(); check("defer_ret_pc", 32'(if_PC), 32'h080);
        idle_inputs();

        // en=0 holds everything
        en = 1'b0;
        tick(); tick();
        idle_inputs();

        // Wrap at the top of the address space
        exe_correction = 2'b11; exe_PBT = 10'h3FF;
        tick(); idle_inputs();
        tick(); check("wrap_pc", 32'(if_PC), 32'h000);
        tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            en              = ($urandom_range(0, 9) != 0);
            stall           = ($urandom_range(0, 4) == 0);
            if_prediction   = ($urandom_range(0, 2) == 0);
            if_PBT          = 10'($urandom);
            exe_correction  = ($urandom_range(0, 6) == 0) ? 2'($urandom) : 2'($urandom_range(0, 1));
            exe_CNI         = 10'($urandom);
            exe_PBT         = 10'($urandom);
            branch_flush    = ($urandom_range(0, 9) == 0);
            id_is_jump      = ($urandom_range(0, 5) == 0);
            id_jump_in_bht  = ($urandom_range(0, 1) == 0);
            id_branchtarget = 10'($urandom);
            isr_req         = ($urandom_range(0, 7) == 0);
            exe_is_mret     = ($urandom_range(0, 4) == 0);
            tick();
        end
        idle_inputs();
        tick();

        // Asynchronous reset between edges
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        check("async_rst_pc", 32'(if_PC), 32'h000);
        check("async_rst_flags", 32'({id_valid, exe_valid, ISR_running, isr_ack}), 32'h0);
        @(negedge CLK);
        nrst = 1'b1;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
